// File: rtl/amp3_sched_pkg.sv
// Shared types and constants for the amp3 sample scheduler.
package amp3_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } sched_state_e;

    localparam logic [1:0] MODE_A    = 2'b00;
    localparam logic [1:0] MODE_B    = 2'b01;
    localparam logic [1:0] MODE_MIX  = 2'b10;
    localparam logic [1:0] MODE_MUTE = 2'b11;

    // Unsigned midscale code for a given sample width; callers truncate to their width.
    function automatic logic [31:0] midscale(input int unsigned width);
        midscale = 32'd1 << (width - 32'd1);
    endfunction

endpackage

// File: rtl/amp3_sample_fifo.sv
// Synchronous first-word-fall-through FIFO holding one source's sample pairs.
module amp3_sample_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/amp3_sample_sched.sv
// Frame-synchronous scheduler feeding amp3_Lite from two buffered sample sources.
module amp3_sample_sched
    import amp3_sched_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int PRIME_LVL  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] a_right,
    input  logic [DATA_W-1:0] a_left,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [DATA_W-1:0] b_right,
    input  logic [DATA_W-1:0] b_left,
    input  logic              RightNLeft,
    output logic [DATA_W-1:0] dataR,
    output logic [DATA_W-1:0] dataL,
    output logic              enable,
    output logic              underrun,
    output logic              busy
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_W-1:0] MID       = DATA_W'(midscale(DATA_W));
    localparam logic [CW-1:0]     PRIME_CNT = CW'(PRIME_LVL);

    sched_state_e        state_r, state_nxt_s;
    logic [1:0]          mode_r;
    logic                rnl_r, rnl_d_r, tick_s;
    logic [2*DATA_W-1:0] a_dout_s, b_dout_s;
    logic [CW-1:0]       a_count_s, b_count_s;
    logic                a_full_s, b_full_s, a_empty_s, b_empty_s;
    logic                sel_a_s, sel_b_s, starved_s, primed_s, drain_done_s;
    logic                frame_s, pop_s, flush_s;
    logic [DATA_W:0]     sum_right_s, sum_left_s;
    logic [DATA_W-1:0]   right_r, left_r, right_nxt_s, left_nxt_s;
    logic                enable_r, underrun_r, busy_r;
    logic                enable_nxt_s, underrun_nxt_s, busy_nxt_s;

    amp3_sample_fifo #(.W(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_s),
        .push  (a_valid),
        .pop   (pop_s & sel_a_s),
        .din   ({a_right, a_left}),
        .dout  (a_dout_s),
        .count (a_count_s),
        .full  (a_full_s),
        .empty (a_empty_s)
    );

    amp3_sample_fifo #(.W(2*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_s),
        .push  (b_valid),
        .pop   (pop_s & sel_b_s),
        .din   ({b_right, b_left}),
        .dout  (b_dout_s),
        .count (b_count_s),
        .full  (b_full_s),
        .empty (b_empty_s)
    );

    assign a_ready = ~a_full_s;
    assign b_ready = ~b_full_s;

    assign sel_a_s = (mode_r == MODE_A) || (mode_r == MODE_MIX);
    assign sel_b_s = (mode_r == MODE_B) || (mode_r == MODE_MIX);

    // Mute selects no source, so it is never starved, always primed and drains at once.
    assign starved_s    = (sel_a_s & a_empty_s) | (sel_b_s & b_empty_s);
    assign primed_s     = (~sel_a_s | (a_count_s >= PRIME_CNT)) &
                          (~sel_b_s | (b_count_s >= PRIME_CNT));
    assign drain_done_s = starved_s | ~(sel_a_s | sel_b_s);

    assign tick_s  = rnl_d_r & ~rnl_r;
    assign frame_s = tick_s && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    assign pop_s   = frame_s & ~starved_s;
    assign flush_s = (state_r != ST_IDLE) && (state_nxt_s == ST_IDLE);

    assign sum_right_s = {1'b0, a_dout_s[2*DATA_W-1:DATA_W]} + {1'b0, b_dout_s[2*DATA_W-1:DATA_W]};
    assign sum_left_s  = {1'b0, a_dout_s[DATA_W-1:0]} + {1'b0, b_dout_s[DATA_W-1:0]};

    // Channel-phase history used to find the frame boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rnl_r   <= 1'b0;
            rnl_d_r <= 1'b0;
        end else begin
            rnl_r   <= RightNLeft;
            rnl_d_r <= rnl_r;
        end
    end

    // FSM state register; the source mode is captured only when leaving IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_A;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == ST_IDLE) && start) begin
                mode_r <= mode;
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = start        ? ST_PRIME : ST_IDLE;
            ST_PRIME: state_nxt_s = primed_s     ? ST_RUN   : ST_PRIME;
            ST_RUN:   state_nxt_s = stop         ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nxt_s = drain_done_s ? ST_IDLE  : ST_DRAIN;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output logic; outputs follow the next state so they align with state_r.
    always_comb begin
        enable_nxt_s   = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
        underrun_nxt_s = 1'b0;
        right_nxt_s    = right_r;
        left_nxt_s     = left_r;
        if (state_nxt_s == ST_IDLE) begin
            right_nxt_s = MID;
            left_nxt_s  = MID;
        end else if (frame_s && (starved_s || (mode_r == MODE_MUTE))) begin
            right_nxt_s    = MID;
            left_nxt_s     = MID;
            underrun_nxt_s = starved_s && (state_r == ST_RUN);
        end else if (frame_s) begin
            case (mode_r)
                MODE_A: begin
                    right_nxt_s = a_dout_s[2*DATA_W-1:DATA_W];
                    left_nxt_s  = a_dout_s[DATA_W-1:0];
                end
                MODE_B: begin
                    right_nxt_s = b_dout_s[2*DATA_W-1:DATA_W];
                    left_nxt_s  = b_dout_s[DATA_W-1:0];
                end
                MODE_MIX: begin
                    right_nxt_s = sum_right_s[DATA_W:1];
                    left_nxt_s  = sum_left_s[DATA_W:1];
                end
                default: begin
                    right_nxt_s = MID;
                    left_nxt_s  = MID;
                end
            endcase
        end else begin
            right_nxt_s = right_r;
            left_nxt_s  = left_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            right_r    <= MID;
            left_r     <= MID;
            enable_r   <= 1'b0;
            underrun_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            right_r    <= right_nxt_s;
            left_r     <= left_nxt_s;
            enable_r   <= enable_nxt_s;
            underrun_r <= underrun_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign dataR    = right_r;
    assign dataL    = left_r;
    assign enable   = enable_r;
    assign underrun = underrun_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_amp3_sample_sched.sv
// Scoreboard bench for amp3_sample_sched: queue-based source model, frame expectations checked by a monitor.
module tb_amp3_sample_sched;
    localparam int DEPTH = 4;
    localparam logic [11:0] MID = 12'h800;

    typedef struct packed {
        logic [11:0] r;
        logic [11:0] l;
        logic        ur;
        logic        en;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, stop, a_valid, b_valid, RightNLeft;
    logic [1:0]  mode;
    logic [11:0] a_right, a_left, b_right, b_left;
    logic        a_ready, b_ready, enable, underrun, busy;
    logic [11:0] dataR, dataL;

    int total = 0;
    int bad   = 0;

    logic [23:0] qa[$];
    logic [23:0] qb[$];
    exp_t        expq[$];
    exp_t        mon_e;
    int          m_mode  = 0;
    bit          running = 1'b0;
    bit          draining = 1'b0;

    amp3_sample_sched #(.DATA_W(12), .FIFO_DEPTH(DEPTH), .PRIME_LVL(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .a_valid(a_valid), .a_ready(a_ready), .a_right(a_right), .a_left(a_left),
        .b_valid(b_valid), .b_ready(b_ready), .b_right(b_right), .b_left(b_left),
        .RightNLeft(RightNLeft), .dataR(dataR), .dataL(dataL),
        .enable(enable), .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit need_a(input int md);
        return (md == 0) || (md == 2);
    endfunction

    function automatic bit need_b(input int md);
        return (md == 1) || (md == 2);
    endfunction

    function automatic bit starved();
        return (need_a(m_mode) && qa.size() == 0) || (need_b(m_mode) && qb.size() == 0);
    endfunction

    task automatic push_src(input int src, input logic [11:0] r, input logic [11:0] l);
        if (src == 0) begin
            check("a_ready", a_ready, qa.size() < DEPTH);
            a_valid = 1'b1; a_right = r; a_left = l;
            if (qa.size() < DEPTH) qa.push_back({r, l});
        end else begin
            check("b_ready", b_ready, qb.size() < DEPTH);
            b_valid = 1'b1; b_right = r; b_left = l;
            if (qb.size() < DEPTH) qb.push_back({r, l});
        end
        @(posedge clk); #1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    // One amp3 frame: model the expected result, then drive the channel phase low/high.
    task automatic frame();
        exp_t e;
        logic [11:0] ar, al, br, bl;
        ar = 12'h0; al = 12'h0; br = 12'h0; bl = 12'h0;
        e.en = running; e.ur = 1'b0; e.r = MID; e.l = MID;
        if (running && m_mode != 3) begin
            if (starved()) begin
                e.ur = !draining;
            end else begin
                if (need_a(m_mode)) {ar, al} = qa.pop_front();
                if (need_b(m_mode)) {br, bl} = qb.pop_front();
                case (m_mode)
                    0: begin e.r = ar; e.l = al; end
                    1: begin e.r = br; e.l = bl; end
                    default: begin
                        e.r = 12'((int'(ar) + int'(br)) / 2);
                        e.l = 12'((int'(al) + int'(bl)) / 2);
                    end
                endcase
            end
        end
        expq.push_back(e);
        RightNLeft = 1'b0;
        repeat (3) @(posedge clk);
        #1 RightNLeft = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int md, input bit with_stop);
        mode = 2'(md); start = 1'b1; stop = with_stop;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        mode = 2'($urandom_range(0, 3));
        m_mode = md; running = 1'b1; draining = 1'b0;
    endtask

    task automatic wait_enable();
        for (int i = 0; i < 20; i++) begin
            if (enable) break;
            @(posedge clk); #1;
        end
        check("enable_rise", enable, 1'b1);
    endtask

    task automatic stop_drain();
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        draining = 1'b1;
        while (m_mode != 3 && !starved()) frame();
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_enable", enable, 1'b0);
        check("idle_dataR", dataR, MID);
        check("idle_dataL", dataL, MID);
        qa.delete(); qb.delete();
        running = 1'b0; draining = 1'b0;
    endtask

    // Monitor: every falling channel phase produces one registered result two edges later.
    initial begin : monitor
        forever begin
            @(negedge RightNLeft);
            @(posedge clk);
            @(posedge clk);
            #1;
            if (expq.size() == 0) begin
                total++; bad++;
                $display("FAIL tick_unexpected: got frame expected none at %0t", $time);
            end else begin
                mon_e = expq.pop_front();
                check("dataR", dataR, mon_e.r);
                check("dataL", dataL, mon_e.l);
                check("underrun", underrun, mon_e.ur);
                check("enable", enable, mon_e.en);
            end
            @(posedge clk); #1;
            check("underrun_pulse", underrun, 1'b0);
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int md, na, nb, nf;
        rst = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
        a_valid = 1'b0; b_valid = 1'b0; RightNLeft = 1'b1;
        a_right = 12'h0; a_left = 12'h0; b_right = 12'h0; b_left = 12'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_enable", enable, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_dataR", dataR, MID);
        check("rst_dataL", dataL, MID);
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_b_ready", b_ready, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;

        // Mode A basic playback, then starvation with count pinned at zero.
        push_src(0, 12'hFFF, 12'h000);
        push_src(0, 12'hFFF, 12'h000);
        check("enable_idle", enable, 1'b0);
        start_run(0, 1'b0);
        wait_enable();
        repeat (4) frame();
        stop_drain();

        // Mix averaging.
        repeat (2) begin
            push_src(0, 12'h100, 12'hFFF);
            push_src(1, 12'h300, 12'h001);
        end
        start_run(2, 1'b0);
        wait_enable();
        repeat (3) frame();
        stop_drain();

        // Full FIFO: fifth push dropped, exactly four entries played back.
        for (int i = 1; i <= 5; i++) push_src(0, 12'(i * 'h111), 12'(i * 'h101));
        check("a_ready_full", a_ready, 1'b0);
        start_run(0, 1'b0);
        wait_enable();
        repeat (5) frame();
        stop_drain();

        // Stop with three entries queued drains exactly those.
        for (int i = 0; i < 3; i++) push_src(1, 12'(12'h0A0 + i), 12'(12'h50 + i));
        start_run(1, 1'b0);
        wait_enable();
        stop_drain();

        // Start and stop together in IDLE act as start.
        push_src(0, 12'h123, 12'h456);
        push_src(0, 12'h789, 12'hABC);
        start_run(0, 1'b1);
        wait_enable();
        repeat (2) frame();
        stop_drain();

        // Stop during PRIME is ignored.
        start_run(1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("prime_busy", busy, 1'b1);
        check("prime_enable", enable, 1'b0);
        stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
        push_src(1, 12'h321, 12'h654);
        push_src(1, 12'h0FE, 12'hDCB);
        wait_enable();
        repeat (3) frame();
        stop_drain();

        // Mute plays midscale with no starvation.
        push_src(0, 12'h111, 12'h222);
        start_run(3, 1'b0);
        wait_enable();
        repeat (2) frame();
        stop_drain();

        // Reset in RUN abandons everything, FIFOs included.
        for (int i = 0; i < 4; i++) push_src(0, 12'(12'h200 + i), 12'(12'h300 + i));
        start_run(0, 1'b0);
        wait_enable();
        frame();
        rst = 1'b0;
        @(posedge clk); #1;
        check("mrst_busy", busy, 1'b0);
        check("mrst_enable", enable, 1'b0);
        check("mrst_dataR", dataR, MID);
        check("mrst_dataL", dataL, MID);
        check("mrst_a_ready", a_ready, 1'b1);
        rst = 1'b1;
        qa.delete(); qb.delete();
        running = 1'b0;
        @(posedge clk); #1;
        push_src(0, 12'hABC, 12'hDEF);
        push_src(0, 12'h135, 12'h246);
        start_run(0, 1'b0);
        wait_enable();
        repeat (3) frame();
        stop_drain();

        // Randomized sessions.
        for (int s = 0; s < 25; s++) begin
            md = $urandom_range(0, 3);
            na = $urandom_range(0, 4);
            nb = $urandom_range(0, 4);
            if (need_a(md) && na < 2) na = 2;
            if (need_b(md) && nb < 2) nb = 2;
            for (int i = 0; i < na; i++) push_src(0, 12'($urandom), 12'($urandom));
            for (int i = 0; i < nb; i++) push_src(1, 12'($urandom), 12'($urandom));
            start_run(md, 1'b0);
            wait_enable();
            nf = $urandom_range(2, 7);
            for (int f = 0; f < nf; f++) begin
                frame();
                if ($urandom_range(0, 1) == 0) push_src(0, 12'($urandom), 12'($urandom));
                if ($urandom_range(0, 2) == 0) push_src(1, 12'($urandom), 12'($urandom));
                if ($urandom_range(0, 4) == 0) begin
                    start = 1'b1; @(posedge clk); #1; start = 1'b0;
                end
            end
            stop_drain();
        end

        for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
        check("scoreboard_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amp3_sample_sched.md
AMP3_SAMPLE_SCHED -- requirements
Module: amp3_sample_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width per channel, matching the amp3_Lite dataR/dataL width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entries per source FIFO, power of two, minimum 2.
REQ-003 SHALL have parameter PRIME_LVL, default 2, number of entries each selected source must hold before playback starts, range 1..FIFO_DEPTH.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 start  in  1  one-cycle pulse; requests playback.
REQ-007 stop  in  1  one-cycle pulse; requests graceful stop.
REQ-008 mode  in  2  source select: 00 = A only, 01 = B only, 10 = mix A+B, 11 = mute; sampled only in IDLE.
REQ-009 a_valid / b_valid  in  1  source pushes a sample pair.
REQ-010 a_ready / b_ready  out  1  source FIFO not full.
REQ-011 a_right, a_left, b_right, b_left  in  DATA_W  unsigned sample pair from each source.
REQ-012 RightNLeft  in  1  channel phase from amp3_Lite.
REQ-013 dataR, dataL  out  DATA_W  samples driven to amp3_Lite.
REQ-014 enable  out  1  amp3_Lite enable.
REQ-015 underrun  out  1  one-cycle pulse on a starved frame.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 Push SHALL occur when x_valid and x_ready are both high in the same cycle; when x_ready is low, x_valid SHALL be ignored and the data dropped, with no stall.
REQ-018 A frame tick SHALL be detected as a 1->0 transition of registered RightNLeft; the tick is the registered edge, one cycle after the input edge.
REQ-019 FSM states: IDLE, PRIME, RUN, DRAIN.
REQ-020 IDLE -> PRIME on start; mode SHALL be latched in the same cycle.
REQ-021 PRIME -> RUN when every selected source FIFO has count >= PRIME_LVL; mute SHALL pass straight through PRIME to RUN in one cycle.
REQ-022 RUN: enable = 1; on each frame tick the block SHALL pop one entry from each selected FIFO and register it to dataR/dataL on the next cycle.
REQ-023 Mix SHALL compute (a + b) >> 1 per channel, using a DATA_W+1 sum with the LSB discarded; no saturation.
REQ-024 Mute SHALL output the midscale value 1 << (DATA_W-1) (12'h800 at default width) every frame.
REQ-025 On a frame tick, if any selected FIFO is empty: no pop from any FIFO, dataR/dataL = midscale, underrun pulses for 1 cycle, and the FSM stays in RUN.
REQ-026 RUN -> DRAIN on stop; DRAIN SHALL continue frame pops until all selected FIFOs are empty, then go to IDLE; an empty FIFO in DRAIN SHALL NOT raise underrun.
REQ-027 On entering IDLE: enable = 0, dataR/dataL = midscale, and both FIFOs SHALL be flushed.
REQ-028 start outside IDLE and stop outside RUN SHALL be ignored; start and stop high in the same IDLE cycle SHALL be treated as start only.
REQ-029 A push and a pop on the same FIFO in the same cycle SHALL leave count unchanged; a push is legal when full only if a pop occurs in that cycle, but x_ready SHALL still reflect not-full only.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be log2(FIFO_DEPTH)+1.

Reset
REQ-031 When rst = 0 at a clock edge: state = IDLE, FIFOs empty, enable = 0, underrun = 0, busy = 0, dataR = dataL = midscale, a_ready = b_ready = 1 on the following cycle.
REQ-032 Reset asserted mid-RUN SHALL abandon the frame immediately, without a drain.

Structure
REQ-033 Package amp3_sched_pkg SHALL hold the FSM state enum, the MODE_A/MODE_B/MODE_MIX/MODE_MUTE constants and the midscale function.
REQ-034 Sub-module amp3_sample_fifo (synchronous, DATA_W*2 wide, FIFO_DEPTH entries, count output) SHALL be instantiated once per source.

Verification
REQ-035 Mode A: push A = (R 12'hFFF, L 12'h000) twice, pulse start, then toggle RightNLeft -> enable rises after 2nd push; dataR/dataL = FFF/000 one cycle after the first tick.
REQ-036 Mix: A = (R 12'h100, L 12'hFFF), B = (R 12'h300, L 12'h001) -> dataR = 12'h200, dataL = 12'h800.
REQ-037 Underrun: mode A, prime 2 entries, run 3 frames -> 3rd tick pulses underrun for 1 cycle, outputs 12'h800, and the FIFO count stays at 0.
REQ-038 Full: 5 pushes to A while IDLE, no ticks -> a_ready low after the 4th push, 5th push dropped, count = 4.
REQ-039 Stop: stop with 3 entries queued -> 3 more ticks pop, then IDLE, enable = 0, busy = 0, no underrun.
REQ-040 Reset: rst low for 1 cycle during RUN -> next cycle IDLE, enable = 0, dataR = dataL = 12'h800, FIFOs empty.
